sisc_rst_seq: RTL and testbench
===============================

Name: sisc_rst_seq

Overview:
- Synthesizable reset sequencer for the SISC processor.
- Takes the board-level asynchronous active-low reset and produces NUM_DOMAINS staged, active-low domain resets: for example PC/fetch, datapath, memory interface.
- Reset assertion is asynchronous; release is synchronous and staggered between domains.
- Supports a synchronous soft-reset request and provides a run-cycle counter that freezes while the processor is halted.

Parameters:
- NUM_DOMAINS, 3: number of reset domains driven (>=1); domain 0 releases first.
- SYNC_STAGES, 2: depth of the reset-release synchronizer (>=2).
- HOLD_CYCLES, 4: cycles reset is held after the synchronized release or a soft request (>=1).
- STAGGER, 2: cycles between successive domain releases (0 = all domains release together).
- CNT_W, 16: width of the run-cycle counter.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_f, input, 1: asynchronous active-low reset.
- soft_rst_req, input, 1: synchronous soft-reset request, sampled each rising edge.
- halt, input, 1: processor halted; freezes cycle_cnt.
- rst_out_f, output, NUM_DOMAINS: per-domain active-low resets.
- ready, output, 1: high when all domains are released (state RUN).
- state, output, 2: current FSM state (ASSERT=0, RELEASE=1, RUN=2).
- cycle_cnt, output, CNT_W: saturating count of non-halted RUN cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_f is asynchronous and active-low.
- rst_f low asynchronously forces:
  - all rst_out_f = 0, ready = 0, state = ASSERT, cycle_cnt = 0;
  - hold and stagger counters = 0;
  - synchronizer flops = 0.
- Synchronizer: SYNC_STAGES flops, shifting in 1 after rst_f deasserts. rst_sync = last stage. Let E0 be the first rising edge after rst_f rises; rst_sync goes high after edge E(SYNC_STAGES-1).
- ASSERT:
  - While rst_sync=1 and soft_rst_req=0, hold_cnt increments each edge.
  - On the edge where hold_cnt reaches HOLD_CYCLES-1, the FSM enters RELEASE and rst_out_f[0] rises on that same edge.
- RELEASE:
  - rst_out_f[i] rises STAGGER*i edges after rst_out_f[0].
  - On the edge that releases domain NUM_DOMAINS-1, the FSM enters RUN and ready rises.
  - Power-up latency: domain i releases at edge E(SYNC_STAGES+HOLD_CYCLES-1+STAGGER*i).
- Degenerate cases:
  - NUM_DOMAINS=1 or STAGGER=0: ASSERT goes to RUN directly. All domains release and ready rises on the same edge, and RELEASE is not visited.
- Released domains stay released until an abort or reset.
- RUN:
  - cycle_cnt increments each edge while halt=0.
  - It holds while halt=1.
  - It saturates at 2^CNT_W-1 with no wrap.
- Soft reset:
  - soft_rst_req=1 sampled in RUN or RELEASE, at edge S: all rst_out_f go to 0, ready=0, cycle_cnt=0, hold_cnt=0, state=ASSERT.
  - Release of domain 0 then occurs at edge S+HOLD_CYCLES, provided the request is low for edges S+1 onward.
- soft_rst_req=1 in ASSERT: hold_cnt is cleared to 0. A held request keeps all domains in reset indefinitely. The hold count restarts after the request drops.
- soft_rst_req while rst_sync=0: no effect.
- rst_f low mid-RELEASE or mid-RUN: immediate asynchronous reassertion of all domains. The full power-up sequence, including the synchronizer, repeats.
- halt and soft_rst_req together in RUN: the soft reset wins.
- Outputs are registered only. No combinational path from inputs to rst_out_f or ready.

Test Plan:
1. Power-up with defaults. tclk=10ns, edges at 5,15,25... ns; rst_f low 0-20ns, then high.
   - Required: rst_out_f=3'b000 until 75ns.
   - rst_out_f[0] rises at 75ns, [1] at 95ns, [2] at 115ns.
   - ready=1 and state=2 at 115ns; cycle_cnt=1 after the 125ns edge.
2. Halt freeze: in RUN, halt=1 for 5 cycles, then 0.
   - Required: cycle_cnt is constant during halt, then resumes +1 per cycle.
3. Soft reset from RUN: 1-cycle soft_rst_req sampled at edge S.
   - Required: rst_out_f=000, ready=0, cycle_cnt=0 at S.
   - Domain 0 rises at S+4, domain 1 at S+6, domain 2 at S+8.
4. Soft reset mid-RELEASE: request sampled 1 edge after domain 0 releases.
   - Required: all domains return to 0 on that edge; state=0.
   - The full HOLD+stagger sequence is replayed.
5. Async reset mid-RUN: rst_f pulsed low for 3ns between clock edges.
   - Required: rst_out_f=000, cycle_cnt=0 and state=0 immediately, without waiting for a clock edge.
   - Release timing is again SYNC_STAGES+HOLD_CYCLES-1 edges after the first edge with rst_f high.
6. Parameter corners:
   - STAGGER=0, NUM_DOMAINS=4: all four bits rise on the same edge as ready, and state is never 1.
   - CNT_W=4: cycle_cnt saturates at 15 after 20 RUN cycles.

Source files
------------

// File: rtl/sisc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : sisc_rst_seq
// Description : Reset sequencer for the SISC processor. Turns the board-level
//               asynchronous active-low reset into NUM_DOMAINS staged
//               active-low domain resets. Assertion is asynchronous, and
//               release is synchronous and staggered. Also handles a
//               synchronous soft-reset request and keeps a saturating
//               run-cycle counter that freezes while the core is halted.
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_rst_seq #(
    parameter int NUM_DOMAINS = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_f,
    input  logic                   soft_rst_req,
    input  logic                   halt,
    output logic [NUM_DOMAINS-1:0] rst_out_f,
    output logic                   ready,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       cycle_cnt
);

    // Edges from domain-0 release to the last domain's release.
    localparam int c_STG_MAX = STAGGER * (NUM_DOMAINS - 1);
    // With a single domain or no stagger, every domain goes straight to RUN.
    localparam bit c_DIRECT  = (NUM_DOMAINS == 1) || (STAGGER == 0);
    localparam int c_HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int c_STG_W   = (c_STG_MAX < 1) ? 1 : $clog2(c_STG_MAX + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_STG_W-1:0]  c_STG_LAST  = c_STG_W'(c_STG_MAX);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    state_t                 state_q,  state_d;
    logic [c_HOLD_W-1:0]    hold_q,   hold_d;
    logic [c_STG_W-1:0]     stg_q,    stg_d;
    logic [NUM_DOMAINS-1:0] rel_q,    rel_d;
    logic                   ready_q,  ready_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   abort;

    // Release synchronizer: shifts in ones once rst_f is high, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // A soft request only aborts a sequence that has already released something.
    assign abort = soft_rst_req && (state_q != ST_ASSERT);

    // Next-state logic: hold count, staggered release, run-cycle counting.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        rel_d   = rel_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;

        if (abort) begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            stg_d   = '0;
            rel_d   = '0;
            ready_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (rst_sync) begin
                        if (soft_rst_req) begin
                            hold_d = '0;
                        end else if (hold_q == c_HOLD_LAST) begin
                            hold_d = '0;
                            stg_d  = '0;
                            if (c_DIRECT) begin
                                rel_d   = '1;
                                ready_d = 1'b1;
                                state_d = ST_RUN;
                            end else begin
                                rel_d   = NUM_DOMAINS'(1);
                                state_d = ST_RELEASE;
                            end
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    stg_d = stg_q + 1'b1;
                    // Domain i is released once STAGGER*i edges have passed since domain 0.
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (stg_d >= c_STG_W'(STAGGER * i)) begin
                            rel_d[i] = 1'b1;
                        end
                    end
                    if (stg_d == c_STG_LAST) begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!halt && (cnt_q != c_CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                    hold_d  = '0;
                    stg_d   = '0;
                    rel_d   = '0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register; every output is taken straight from here.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            stg_q   <= '0;
            rel_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            rel_q   <= rel_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rst_out_f = rel_q;
    assign ready     = ready_q;
    assign state     = state_q;
    assign cycle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sisc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sisc_rst_seq
// Description : Self-checking bench for sisc_rst_seq. Three instances share
//               one stimulus stream: defaults, a 4-domain no-stagger corner,
//               and a 4-bit counter with deeper sync / shorter hold. Each is
//               compared every cycle against a timeline-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_rst_seq;

    logic        clk;
    logic        rst_f;
    logic        soft_rst_req;
    logic        halt;

    logic [2:0]  ro_a;
    logic        rdy_a;
    logic [1:0]  st_a;
    logic [15:0] cnt_a;
    logic [3:0]  ro_b;
    logic        rdy_b;
    logic [1:0]  st_b;
    logic [15:0] cnt_b;
    logic [2:0]  ro_c;
    logic        rdy_c;
    logic [1:0]  st_c;
    logic [3:0]  cnt_c;

    sisc_rst_seq u_a (
        .clk(clk), .rst_f(rst_f), .soft_rst_req(soft_rst_req), .halt(halt),
        .rst_out_f(ro_a), .ready(rdy_a), .state(st_a), .cycle_cnt(cnt_a)
    );

    sisc_rst_seq #(.NUM_DOMAINS(4), .STAGGER(0)) u_b (
        .clk(clk), .rst_f(rst_f), .soft_rst_req(soft_rst_req), .halt(halt),
        .rst_out_f(ro_b), .ready(rdy_b), .state(st_b), .cycle_cnt(cnt_b)
    );

    sisc_rst_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst_f(rst_f), .soft_rst_req(soft_rst_req), .halt(halt),
        .rst_out_f(ro_c), .ready(rdy_c), .state(st_c), .cycle_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance parameters as seen by the model.
    int p_n[3]    = '{3, 4, 3};
    int p_stg[3]  = '{2, 0, 2};
    int p_hold[3] = '{4, 4, 2};
    int p_sync[3] = '{2, 2, 3};
    int p_max[3]  = '{65535, 65535, 15};

    // Model state: edges seen with rst_f high, qualifying hold edges,
    // absolute edge of domain-0 release (-1 = none), run-cycle count.
    int m_hi[3];
    int m_quiet[3];
    int m_rel0[3];
    int m_cnt[3];
    int g_edge;

    int n_vec;
    int n_miss;

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_hi[d]    = 0;
            m_quiet[d] = 0;
            m_rel0[d]  = -1;
            m_cnt[d]   = 0;
        end
    endtask

    function automatic int span(int d);
        return p_stg[d] * (p_n[d] - 1);
    endfunction

    task automatic model_edge(input logic s, input logic h, input logic r);
        bit sync_ok;
        g_edge++;
        for (int d = 0; d < 3; d++) begin
            if (!r) begin
                m_hi[d] = 0; m_quiet[d] = 0; m_rel0[d] = -1; m_cnt[d] = 0;
            end else begin
                sync_ok = (m_hi[d] >= p_sync[d]);
                m_hi[d]++;
                if (m_rel0[d] < 0) begin
                    if (sync_ok) begin
                        if (s) begin
                            m_quiet[d] = 0;
                        end else begin
                            m_quiet[d]++;
                            if (m_quiet[d] == p_hold[d]) m_rel0[d] = g_edge;
                        end
                    end
                end else if (s) begin
                    m_rel0[d] = -1; m_quiet[d] = 0; m_cnt[d] = 0;
                end else if ((g_edge > m_rel0[d] + span(d)) && !h) begin
                    if (m_cnt[d] < p_max[d]) m_cnt[d]++;
                end
            end
        end
    endtask

    function automatic int exp_rst(int d);
        int v = 0;
        if (m_rel0[d] >= 0)
            for (int i = 0; i < p_n[d]; i++)
                if (g_edge >= m_rel0[d] + p_stg[d] * i) v |= (1 << i);
        return v;
    endfunction

    function automatic int exp_rdy(int d);
        return ((m_rel0[d] >= 0) && (g_edge >= m_rel0[d] + span(d))) ? 1 : 0;
    endfunction

    function automatic int exp_st(int d);
        if (m_rel0[d] < 0) return 0;
        return (exp_rdy(d) != 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_all();
        chk("A.rst_out_f", ro_a, exp_rst(0));
        chk("A.ready", rdy_a, exp_rdy(0));
        chk("A.state", st_a, exp_st(0));
        chk("A.cycle_cnt", cnt_a, m_cnt[0]);
        chk("B.rst_out_f", ro_b, exp_rst(1));
        chk("B.ready", rdy_b, exp_rdy(1));
        chk("B.state", st_b, exp_st(1));
        chk("B.cycle_cnt", cnt_b, m_cnt[1]);
        chk("C.rst_out_f", ro_c, exp_rst(2));
        chk("C.ready", rdy_c, exp_rdy(2));
        chk("C.state", st_c, exp_st(2));
        chk("C.cycle_cnt", cnt_c, m_cnt[2]);
    endtask

    task automatic step(input logic s, input logic h);
        soft_rst_req = s;
        halt         = h;
        @(posedge clk);
        model_edge(s, h, rst_f);
        #1;
        check_all();
    endtask

    // Short low pulse on rst_f between edges; outputs must clear at once.
    task automatic async_pulse();
        #2 rst_f = 1'b0;
        model_clear();
        #1 check_all();
        chk("A.async_rst", ro_a, 0);
        chk("A.async_cnt", cnt_a, 0);
        #2 rst_f = 1'b1;
    endtask

    task automatic wait_dom0();
        for (int k = 0; k < 20 && ro_a[0] !== 1'b1; k++) step(1'b0, 1'b0);
        chk("A.dom0_timeout", ro_a[0], 1);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; g_edge = 0;
        rst_f = 1'b1; soft_rst_req = 1'b0; halt = 1'b0;
        model_clear();
        #1 rst_f = 1'b0;
        #1 check_all();

        // Power-up: rst_f low until 20 ns.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #4 rst_f = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0);
            chk("A.pre_release", ro_a, 0);
        end
        step(1'b0, 1'b0);
        chk("A.dom0_75ns", ro_a, 3'b001);
        chk("B.all_75ns", ro_b, 4'b1111);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("A.dom1_95ns", ro_a, 3'b011);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("A.dom2_115ns", ro_a, 3'b111);
        chk("A.ready_115ns", rdy_a, 1);
        chk("A.state_115ns", st_a, 2);
        step(1'b0, 1'b0);
        chk("A.cnt_125ns", cnt_a, 1);

        // Halt freeze then resume.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1);
            chk("A.halt_freeze", cnt_a, 5);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        chk("A.halt_resume", cnt_a, 8);

        // Soft reset from RUN, one-cycle request at edge S.
        step(1'b1, 1'b0);
        chk("A.soft_rst_out", ro_a, 0);
        chk("A.soft_ready", rdy_a, 0);
        chk("A.soft_cnt", cnt_a, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        chk("A.soft_s3", ro_a, 0);
        step(1'b0, 1'b0);
        chk("A.soft_s4", ro_a, 3'b001);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("A.soft_s6", ro_a, 3'b011);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("A.soft_s8", ro_a, 3'b111);

        // Soft reset mid-RELEASE, one edge after domain 0 releases.
        step(1'b1, 1'b0);
        wait_dom0();
        step(1'b1, 1'b0);
        chk("A.midrel_rst", ro_a, 0);
        chk("A.midrel_state", st_a, 0);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0);
        chk("A.midrel_replay", ro_a, 3'b111);

        // Asynchronous reset mid-RUN.
        async_pulse();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        chk("A.async_pre", ro_a, 0);
        step(1'b0, 1'b0);
        chk("A.async_dom0", ro_a, 3'b001);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b0);
        chk("C.saturate", cnt_c, 15);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 2) async_pulse();
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
